// File: rtl/pc_fetch_sequencer.sv
// PC register and single-outstanding instruction fetch sequencer for the LEGv8 core.
// Fetches over req/ack, presents to decode over valid/ready, and applies taken-branch redirects.
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        br_valid,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_imm,
  input  logic        br_cond,
  input  logic        br_zero,
  input  logic        br_uncond,
  output logic        redirect,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [7:0]  TIMEOUT_W   = 8'(TIMEOUT);
  localparam logic [63:0] RESET_PC_AL = {RESET_PC[63:2], 2'b00};

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        redirect_q, redirect_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  wait_q, wait_d;

  logic        taken;
  logic [63:0] target;

  assign taken  = br_valid & (br_uncond | (br_cond & br_zero));
  assign target = br_pc + (br_imm << 2);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    redirect_d   = 1'b0;
    fetch_err_d  = fetch_err_q;
    wait_d       = wait_q;

    unique case (state_q)
      S_FETCH: begin
        if (taken) begin
          pc_d         = {target[63:2], 2'b00};
          inst_valid_d = 1'b0;
          redirect_d   = 1'b1;
          wait_d       = '0;
        end else if (imem_req_q && imem_ack) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 64'd4;
          wait_d       = '0;
          state_d      = S_HOLD;
        end else if (imem_req_q) begin
          // Only cycles with a request outstanding count toward the timeout.
          wait_d = wait_q + 8'd1;
          if (wait_d == TIMEOUT_W) begin
            state_d     = S_HALT;
            fetch_err_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (taken) begin
          pc_d         = {target[63:2], 2'b00};
          inst_valid_d = 1'b0;
          redirect_d   = 1'b1;
          wait_d       = '0;
          state_d      = S_FETCH;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_HALT: begin
        inst_valid_d = 1'b0;
        fetch_err_d  = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC_AL;
      imem_req_q   <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      redirect_q   <= redirect_d;
      fetch_err_q  <= fetch_err_d;
      wait_q       <= wait_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign redirect   = redirect_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: fetch/decode handshake, branch redirects,
// PC wrap, ack/branch collision, timeout halt and reset recovery.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_valid;
  logic [63:0] br_pc;
  logic [63:0] br_imm;
  logic        br_cond;
  logic        br_zero;
  logic        br_uncond;
  logic        redirect;
  logic        fetch_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 CLK = ~CLK;

  pc_fetch_sequencer #(
    .RESET_PC(64'h0),
    .TIMEOUT (16)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .br_valid  (br_valid),
    .br_pc     (br_pc),
    .br_imm    (br_imm),
    .br_cond   (br_cond),
    .br_zero   (br_zero),
    .br_uncond (br_uncond),
    .redirect  (redirect),
    .fetch_err (fetch_err)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_br();
    br_valid  = 1'b0;
    br_pc     = '0;
    br_imm    = '0;
    br_cond   = 1'b0;
    br_zero   = 1'b0;
    br_uncond = 1'b0;
  endtask

  task automatic set_br(input logic c, input logic z, input logic u,
                        input logic [63:0] pc, input logic [63:0] imm);
    br_valid  = 1'b1;
    br_cond   = c;
    br_zero   = z;
    br_uncond = u;
    br_pc     = pc;
    br_imm    = imm;
  endtask

  initial begin
    Reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    inst_ready = 1'b0;
    clear_br();
    cyc();
    cyc();

    // Reset state
    chk1 ("rst_req",      imem_req,   1'b0);
    chk1 ("rst_valid",    inst_valid, 1'b0);
    chk64("rst_inst",     64'(inst),  64'h0);
    chk64("rst_inst_pc",  inst_pc,    64'h0);
    chk1 ("rst_redirect", redirect,   1'b0);
    chk1 ("rst_err",      fetch_err,  1'b0);
    chk64("rst_addr",     imem_addr,  64'h0);

    Reset = 1'b0;
    cyc();
    chk1 ("req_rise", imem_req,  1'b1);
    chk64("req_addr", imem_addr, 64'h0);

    // T1: ack with instruction word
    imem_ack   = 1'b1;
    imem_rdata = 32'h8B020020;
    cyc();
    imem_ack   = 1'b0;
    chk1 ("t1_valid",   inst_valid, 1'b1);
    chk64("t1_inst",    64'(inst),  64'h8B020020);
    chk64("t1_inst_pc", inst_pc,    64'h0);
    chk1 ("t1_req_off", imem_req,   1'b0);
    cyc();
    chk1 ("t1_hold_valid", inst_valid, 1'b1);
    chk1 ("t1_hold_req",   imem_req,   1'b0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk1 ("t1_ready_valid", inst_valid, 1'b0);
    chk1 ("t1_ready_req",   imem_req,   1'b1);
    chk64("t1_next_addr",   imem_addr,  64'h4);

    // T2: unconditional branch in FETCH
    set_br(1'b0, 1'b0, 1'b1, 64'h0, 64'h3);
    cyc();
    clear_br();
    chk1 ("t2_redirect", redirect,   1'b1);
    chk64("t2_addr",     imem_addr,  64'hC);
    chk1 ("t2_valid",    inst_valid, 1'b0);
    chk1 ("t2_req",      imem_req,   1'b1);
    cyc();
    chk1 ("t2_pulse_end", redirect, 1'b0);

    // Fetch at 0xC, then T3: conditional taken branch in HOLD together with inst_ready
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA0001;
    cyc();
    imem_ack   = 1'b0;
    chk64("t3_pre_inst_pc", inst_pc,    64'hC);
    chk1 ("t3_pre_valid",   inst_valid, 1'b1);
    set_br(1'b1, 1'b1, 1'b0, 64'h100, 64'h1);
    inst_ready = 1'b1;
    cyc();
    clear_br();
    inst_ready = 1'b0;
    chk64("t3_addr",     imem_addr,  64'h104);
    chk1 ("t3_redirect", redirect,   1'b1);
    chk1 ("t3_flush",    inst_valid, 1'b0);
    chk1 ("t3_req",      imem_req,   1'b1);

    // T3b: conditional not taken (zero=0) alongside an ack
    set_br(1'b1, 1'b0, 1'b0, 64'h200, 64'h5);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBBBB0002;
    cyc();
    clear_br();
    imem_ack   = 1'b0;
    chk1 ("t3b_redirect", redirect,   1'b0);
    chk1 ("t3b_valid",    inst_valid, 1'b1);
    chk64("t3b_inst",     64'(inst),  64'hBBBB0002);
    chk64("t3b_inst_pc",  inst_pc,    64'h104);
    chk64("t3b_addr",     imem_addr,  64'h108);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk1 ("t3b_req", imem_req, 1'b1);

    // T4: negative immediate, then PC wrap at the top of the address space
    set_br(1'b0, 1'b0, 1'b1, 64'h100, 64'hFFFFFFFFFFFFFFFE);
    cyc();
    clear_br();
    chk64("t4_neg_addr", imem_addr, 64'hF8);
    chk1 ("t4_redirect", redirect,  1'b1);
    set_br(1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h0);
    cyc();
    clear_br();
    chk64("t4_top_addr", imem_addr, 64'hFFFFFFFFFFFFFFFC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hCCCC0003;
    cyc();
    imem_ack   = 1'b0;
    chk64("t4_wrap_addr",    imem_addr, 64'h0);
    chk64("t4_wrap_inst_pc", inst_pc,   64'hFFFFFFFFFFFFFFFC);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk1 ("t4_req", imem_req, 1'b1);

    // T6: ack and taken branch in the same cycle -> ack discarded
    imem_ack   = 1'b1;
    imem_rdata = 32'hDDDD0004;
    set_br(1'b0, 1'b0, 1'b1, 64'h20, 64'h8);
    cyc();
    imem_ack = 1'b0;
    clear_br();
    chk1 ("t6_valid",    inst_valid, 1'b0);
    chk64("t6_addr",     imem_addr,  64'h40);
    chk1 ("t6_redirect", redirect,   1'b1);
    chk64("t6_inst",     64'(inst),  64'hCCCC0003);
    chk1 ("t6_req",      imem_req,   1'b1);

    // T5: 16 un-acked request cycles -> HALT
    cyc();
    chk1("t6_after_valid", inst_valid, 1'b0);
    for (int i = 0; i < 14; i++) cyc();
    chk1("t5_pre_err", fetch_err, 1'b0);
    chk1("t5_pre_req", imem_req,  1'b1);
    cyc();
    chk1("t5_err", fetch_err, 1'b1);
    chk1("t5_req", imem_req,  1'b0);

    // HALT ignores ack, ready and taken branches
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    set_br(1'b0, 1'b0, 1'b1, 64'h0, 64'h10);
    cyc();
    cyc();
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    clear_br();
    chk1 ("t5_halt_err",      fetch_err,  1'b1);
    chk1 ("t5_halt_req",      imem_req,   1'b0);
    chk1 ("t5_halt_valid",    inst_valid, 1'b0);
    chk1 ("t5_halt_redirect", redirect,   1'b0);
    chk64("t5_halt_addr",     imem_addr,  64'h40);

    Reset = 1'b1;
    cyc();
    chk1 ("t5_rst_err",  fetch_err, 1'b0);
    chk64("t5_rst_addr", imem_addr, 64'h0);
    chk1 ("t5_rst_req",  imem_req,  1'b0);
    Reset = 1'b0;
    cyc();
    chk1("t5_rerun_req", imem_req, 1'b1);

    // Reset with a concurrent ack: the ack is ignored
    Reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hEEEE0005;
    cyc();
    Reset    = 1'b0;
    imem_ack = 1'b0;
    chk1 ("rst_ack_valid", inst_valid, 1'b0);
    chk64("rst_ack_inst",  64'(inst),  64'h0);
    chk64("rst_ack_addr",  imem_addr,  64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
